operand_fetch_stage: RTL and testbench

Operand-fetch stage sitting directly upstream of the ALU in the RISC-V datapath. Holds the 32-entry integer register file (two read ports, one write-back port) and a registered EX-side operand latch that presents A, B, 4-bit ALU control and destination register to the ALU. A valid/ready handshake on both sides lets the ALU side stall. Optional write-back bypass keeps operands coherent with same-cycle and in-stall register writes.

---
 rtl/opfetch_pkg.sv | 19 +
 rtl/regfile_2r1w.sv | 48 ++++
 rtl/operand_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared parameters for the operand-fetch stage.
//   XLEN / NREGS / REG_AW : datapath width, register count, address width
//   ALU_*                 : 4-bit ALU operation codes carried to EX
//   ex_state_t            : EX latch occupancy (EMPTY / FULL)
package opfetch_pkg;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic {
    EX_EMPTY = 1'b0,
    EX_FULL  = 1'b1
  } ex_state_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: integer register file, two combinational read ports and
// one write port. x0 always reads zero and ignores writes.
//   clk, reset_n      : clock, asynchronous active-low reset (clears all)
//   we, waddr, wdata  : write port, applied at the rising edge
//   raddr1 / rdata1   : read port 1 (combinational)
//   raddr2 / rdata2   : read port 2 (combinational)
module regfile_2r1w
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs_q [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [XLEN-1:0] reg_d;

      if (gi == 0) begin : g_zero
        // x0 is hard-wired; the flop never leaves its reset value.
        always_comb reg_d = '0;
      end else begin : g_gpr
        always_comb begin
          reg_d = regs_q[gi];
          if (we && (waddr == REG_AW'(gi))) reg_d = wdata;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) regs_q[gi] <= '0;
        else          regs_q[gi] <= reg_d;
      end
    end
  endgenerate

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads source operands from the register file and
// holds them in an EX-side latch for the ALU, with valid/ready handshakes
// on the decode side (id_*) and the ALU side (ex_*).
//   clk, reset_n         : clock, asynchronous active-low reset
//   id_valid / id_ready  : decode handshake
//   id_rs1, id_rs2, id_rd: source / destination register addresses
//   id_imm, id_alu_src   : immediate and B-operand select (1 = immediate)
//   id_alu_ctrl          : ALU operation code
//   flush                : drop the instruction held in the EX latch
//   wb_en, wb_addr, wb_data : register write-back port
//   ex_valid / ex_ready  : ALU handshake
//   ex_a, ex_b, ex_alu_ctrl, ex_rd : held operands and control
// Build option: define OPFETCH_BYPASS_EN to forward write-back data into
// operands read in the accept cycle and into operands held during a stall.
module operand_fetch_stage
  import opfetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [3:0]        ex_alu_ctrl,
  output logic [REG_AW-1:0] ex_rd
);

  ex_state_t         state_q, state_d;
  logic [XLEN-1:0]   ex_a_q, ex_a_d;
  logic [XLEN-1:0]   ex_b_q, ex_b_d;
  logic [3:0]        ex_alu_ctrl_q, ex_alu_ctrl_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            accept;

  regfile_2r1w u_regfile (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (id_rs1),
    .raddr2 (id_rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  assign id_ready = !flush && ((state_q == EX_EMPTY) || ex_ready);
  assign accept   = id_valid && id_ready;

`ifdef OPFETCH_BYPASS_EN
  // Source addresses and B-source kind of the held instruction, kept only
  // so in-stall write-backs can find the operands they must refresh.
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic              b_is_reg_q, b_is_reg_d;
  logic              wb_live;

  assign wb_live = wb_en && (wb_addr != '0);
  // A write landing in the accept cycle is not yet in the array.
  assign rs1_val = (wb_live && (wb_addr == id_rs1)) ? wb_data : rf_rdata1;
  assign rs2_val = (wb_live && (wb_addr == id_rs2)) ? wb_data : rf_rdata2;
`else
  assign rs1_val = rf_rdata1;
  assign rs2_val = rf_rdata2;
`endif

  always_comb begin
    state_d       = state_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    ex_alu_ctrl_d = ex_alu_ctrl_q;
    ex_rd_d       = ex_rd_q;
`ifdef OPFETCH_BYPASS_EN
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    b_is_reg_d    = b_is_reg_q;
`endif

    // accept already excludes flush, so flush wins over any load.
    case (state_q)
      EX_EMPTY: if (accept) state_d = EX_FULL;
      EX_FULL: begin
        if (flush)                    state_d = EX_EMPTY;
        else if (ex_ready && !accept) state_d = EX_EMPTY;
      end
      default: state_d = EX_EMPTY;
    endcase

    if (accept) begin
      ex_a_d        = rs1_val;
      ex_b_d        = id_alu_src ? id_imm : rs2_val;
      ex_alu_ctrl_d = id_alu_ctrl;
      ex_rd_d       = id_rd;
`ifdef OPFETCH_BYPASS_EN
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      b_is_reg_d    = !id_alu_src;
`endif
    end
`ifdef OPFETCH_BYPASS_EN
    else if (state_q == EX_FULL) begin
      // Keep held operands coherent with writes arriving while stalled.
      if (wb_live && (wb_addr == ex_rs1_q))               ex_a_d = wb_data;
      if (wb_live && b_is_reg_q && (wb_addr == ex_rs2_q)) ex_b_d = wb_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EX_EMPTY;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_alu_ctrl_q <= ALU_AND;
      ex_rd_q       <= '0;
    end else begin
      state_q       <= state_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_alu_ctrl_q <= ex_alu_ctrl_d;
      ex_rd_q       <= ex_rd_d;
    end
  end

`ifdef OPFETCH_BYPASS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      b_is_reg_q <= 1'b0;
    end else begin
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      b_is_reg_q <= b_is_reg_d;
    end
  end
`endif

  assign ex_valid    = (state_q == EX_FULL);
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_alu_ctrl = ex_alu_ctrl_q;
  assign ex_rd       = ex_rd_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed bench for operand_fetch_stage.
// Expected operand values follow OPFETCH_BYPASS_EN when it is defined.
module tb_operand_fetch_stage;
  import opfetch_pkg::*;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              id_valid, id_ready;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_imm;
  logic              id_alu_src;
  logic [3:0]        id_alu_ctrl;
  logic              flush;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              ex_valid, ex_ready;
  logic [XLEN-1:0]   ex_a, ex_b;
  logic [3:0]        ex_alu_ctrl;
  logic [REG_AW-1:0] ex_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd)
  );

  // Inputs change 1 time unit after the rising edge; outputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic src, input logic [31:0] imm,
                        input logic [3:0] ctrl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_alu_src = src; id_imm = imm; id_alu_ctrl = ctrl;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    set_wb(1'b0, 5'd0, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_a !== 32'h0) begin errors++; $display("FAIL reset_ex_a got=%h exp=0", ex_a); end
    checks++; if (ex_b !== 32'h0) begin errors++; $display("FAIL reset_ex_b got=%h exp=0", ex_b); end
    checks++; if (ex_alu_ctrl !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", ex_alu_ctrl); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", ex_rd); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got=%b exp=1", id_ready); end
    $display("reset: ex_valid=%b id_ready=%b", ex_valid, id_ready);
  endtask

  task automatic test_basic();
    tick();
    set_wb(1'b1, 5'd5, 32'h0000_00AA);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd5, 5'd0, 5'd9, 1'b0, 32'h0, ALU_ADD);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", ex_valid); end
    checks++; if (ex_a !== 32'hAA) begin errors++; $display("FAIL basic_a got=%h exp=000000aa", ex_a); end
    checks++; if (ex_b !== 32'h0) begin errors++; $display("FAIL basic_b got=%h exp=0", ex_b); end
    checks++; if (ex_alu_ctrl !== 4'b0010) begin errors++; $display("FAIL basic_ctrl got=%b exp=0010", ex_alu_ctrl); end
    checks++; if (ex_rd !== 5'd9) begin errors++; $display("FAIL basic_rd got=%0d exp=9", ex_rd); end
    $display("basic: a=%h b=%h ctrl=%b rd=%0d", ex_a, ex_b, ex_alu_ctrl, ex_rd);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", ex_valid); end
    $display("drain: ex_valid=%b", ex_valid);
  endtask

  task automatic test_x0();
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd0, 5'd5, 5'd1, 1'b0, 32'h0, ALU_OR);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    checks++; if (ex_a !== 32'h0) begin errors++; $display("FAIL x0_a got=%h exp=0", ex_a); end
    checks++; if (ex_b !== 32'hAA) begin errors++; $display("FAIL x0_b got=%h exp=000000aa", ex_b); end
    $display("x0: a=%h b=%h", ex_a, ex_b);
    tick();
  endtask

  task automatic test_imm();
    set_wb(1'b1, 5'd3, 32'h0000_0033);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd5, 5'd3, 5'd2, 1'b1, 32'hFFFF_FFFC, ALU_ADD);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    checks++; if (ex_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_b got=%h exp=fffffffc", ex_b); end
    checks++; if (ex_a !== 32'hAA) begin errors++; $display("FAIL imm_a got=%h exp=000000aa", ex_a); end
    $display("imm: a=%h b=%h", ex_a, ex_b);
    tick();
  endtask

  task automatic test_bypass_and_back_to_back();
    logic [31:0] exp_a;
    set_wb(1'b1, 5'd7, 32'h1);
    tick();
    // Same-cycle write to x7 while accepting rs1=7.
    set_wb(1'b1, 5'd7, 32'h1234);
    set_id(1'b1, 5'd7, 5'd0, 5'd10, 1'b0, 32'h0, ALU_ADD);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    exp_a = BP ? 32'h1234 : 32'h1;
    checks++; if (ex_a !== exp_a) begin errors++; $display("FAIL bypass_a got=%h exp=%h", ex_a, exp_a); end
    $display("bypass(%0d): a=%h", BP, ex_a);
    // Back-to-back accepts with ex_ready held high.
    set_id(1'b1, 5'd7, 5'd5, 5'd11, 1'b0, 32'h0, ALU_SUB);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'h1234 || ex_b !== 32'hAA || ex_rd !== 5'd11)
      begin errors++; $display("FAIL b2b_1 got=%b/%h/%h/%0d exp=1/00001234/000000aa/11", ex_valid, ex_a, ex_b, ex_rd); end
    set_id(1'b1, 5'd5, 5'd7, 5'd12, 1'b0, 32'h0, ALU_OR);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'hAA || ex_b !== 32'h1234 || ex_rd !== 5'd12)
      begin errors++; $display("FAIL b2b_2 got=%b/%h/%h/%0d exp=1/000000aa/00001234/12", ex_valid, ex_a, ex_b, ex_rd); end
    $display("back_to_back: a=%h b=%h rd=%0d", ex_a, ex_b, ex_rd);
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] exp_a, exp_b;
    set_id(1'b1, 5'd5, 5'd3, 5'd4, 1'b0, 32'h0, ALU_AND);
    tick();
    ex_ready = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 32'h0, ALU_OR);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_id_ready got=%b exp=0", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'hAA || ex_b !== 32'h33 || ex_rd !== 5'd4 || ex_alu_ctrl !== ALU_AND)
      begin errors++; $display("FAIL stall_hold got=%b/%h/%h/%0d exp=1/000000aa/00000033/4", ex_valid, ex_a, ex_b, ex_rd); end
    set_wb(1'b1, 5'd5, 32'h55);
    tick();
    exp_a = BP ? 32'h55 : 32'hAA;
    checks++; if (ex_a !== exp_a || ex_b !== 32'h33) begin errors++; $display("FAIL stall_wb_rs1 got=%h/%h exp=%h/00000033", ex_a, ex_b, exp_a); end
    set_wb(1'b1, 5'd3, 32'h77);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    exp_b = BP ? 32'h77 : 32'h33;
    checks++; if (ex_b !== exp_b || ex_a !== exp_a || ex_rd !== 5'd4) begin errors++; $display("FAIL stall_wb_rs2 got=%h/%h exp=%h/%h", ex_a, ex_b, exp_a, exp_b); end
    $display("stall: a=%h b=%h", ex_a, ex_b);
    // Release: consume and accept in the same edge.
    ex_ready = 1'b1;
    set_id(1'b1, 5'd3, 5'd5, 5'd8, 1'b0, 32'h0, ALU_SUB);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'h77 || ex_b !== 32'h55 || ex_alu_ctrl !== ALU_SUB || ex_rd !== 5'd8)
      begin errors++; $display("FAIL release got=%b/%h/%h/%b/%0d exp=1/00000077/00000055/0110/8", ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_rd); end
    $display("release: a=%h b=%h", ex_a, ex_b);
    // Immediate B operand must not be refreshed by a write to its rs2 field.
    set_id(1'b1, 5'd0, 5'd7, 5'd13, 1'b1, 32'h10, ALU_ADD);
    tick();
    ex_ready = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    set_wb(1'b1, 5'd7, 32'h99);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    checks++; if (ex_b !== 32'h10 || ex_a !== 32'h0 || ex_valid !== 1'b1) begin errors++; $display("FAIL imm_no_refresh got=%b/%h/%h exp=1/0/00000010", ex_valid, ex_a, ex_b); end
    $display("imm_hold: a=%h b=%h", ex_a, ex_b);
  endtask

  task automatic test_flush();
    // FULL and stalled from the previous task.
    flush = 1'b1;
    set_id(1'b1, 5'd5, 5'd5, 5'd14, 1'b0, 32'h0, ALU_OR);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_id_ready got=%b exp=0", id_ready); end
    tick();
    flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    checks++; if (ex_valid !== 1'b0 || ex_a !== 32'h0 || ex_rd !== 5'd13) begin errors++; $display("FAIL flush got=%b/%h/%0d exp=0/0/13", ex_valid, ex_a, ex_rd); end
    $display("flush: ex_valid=%b", ex_valid);
  endtask

  task automatic test_reset_mid_stall();
    ex_ready = 1'b1;
    set_id(1'b1, 5'd5, 5'd3, 5'd15, 1'b0, 32'h0, ALU_ADD);
    tick();
    ex_ready = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'h55) begin errors++; $display("FAIL pre_reset got=%b/%h exp=1/00000055", ex_valid, ex_a); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_a !== 32'h0 || ex_b !== 32'h0 || ex_rd !== 5'd0)
      begin errors++; $display("FAIL async_reset got=%b/%h/%h/%0d exp=0/0/0/0", ex_valid, ex_a, ex_b, ex_rd); end
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", id_ready); end
    set_id(1'b1, 5'd5, 5'd7, 5'd3, 1'b0, 32'h0, ALU_ADD);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, ALU_AND);
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'h0 || ex_b !== 32'h0) begin errors++; $display("FAIL regs_cleared got=%b/%h/%h exp=1/0/0", ex_valid, ex_a, ex_b); end
    $display("reset_mid_stall: a=%h b=%h", ex_a, ex_b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_imm();
    test_bypass_and_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
